// File: rtl/dmem_sync.sv
// Synchronous single-port data memory: registered reads, byte-enable writes, hardware clear sequencer.
// Optional build macro DMEM_ADDR_CHECK_EN enables out-of-range address detection (rsp_err).
module dmem_sync #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 22,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  input  logic                    clear_start,
  output logic                    clear_busy
);

  localparam int unsigned IDX_BITS = $clog2(DEPTH);
  localparam int unsigned BE_W     = DATA_WIDTH / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_BITS-1:0]   clr_idx_q, clr_idx_d;
  logic                  req_ready_q, req_ready_d;
  logic                  clear_busy_q, clear_busy_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  acc_c;
  logic                  addr_ok_c;
  logic                  clr_we_c;
  logic                  wr_en_c;
  logic [IDX_BITS-1:0]   idx_c;

  assign idx_c = req_addr[IDX_BITS-1:0];

`ifdef DMEM_ADDR_CHECK_EN
  assign addr_ok_c = ((req_addr >> IDX_BITS) == '0);
`else
  logic unused_addr_c;
  assign unused_addr_c = ^req_addr[ADDR_WIDTH-1:IDX_BITS];
  assign addr_ok_c     = 1'b1;
`endif

  assign acc_c   = req_valid && req_ready_q && !reset;
  assign wr_en_c = acc_c && req_write && addr_ok_c;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR;
      clr_idx_q    <= '0;
      req_ready_q  <= 1'b0;
      clear_busy_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      req_ready_q  <= req_ready_d;
      clear_busy_q <= clear_busy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Next-state, clear sequencing and response formation
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    clr_we_c    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      CLEAR: begin
        clr_we_c  = !reset;
        clr_idx_d = clr_idx_q + IDX_BITS'(1);
        if (clr_idx_q == IDX_BITS'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (clear_start) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase

    if (acc_c) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = (req_write || !addr_ok_c) ? '0 : mem_q[idx_c];
`ifdef DMEM_ADDR_CHECK_EN
      rsp_err_d   = !addr_ok_c;
`else
      rsp_err_d   = 1'b0;
`endif
    end

    req_ready_d  = (state_d == RUN);
    clear_busy_d = (state_d == CLEAR);
  end

  // Data array; the clear and request writes are mutually exclusive by state
  always_ff @(posedge clk) begin
    if (clr_we_c) begin
      mem_q[clr_idx_q] <= '0;
    end else if (wr_en_c) begin
      for (int b = 0; b < BE_W; b++) begin
        if (req_be[b]) begin
          mem_q[idx_c][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign clear_busy = clear_busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_dmem_sync.sv
// Self-checking bench for dmem_sync: directed plan plus randomized traffic against a behavioural model.
module tb_dmem_sync;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 22;
  localparam int unsigned DEPTH = 256;
`ifdef DMEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          clear_start;
  logic          clear_busy;

  dmem_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .clear_start(clear_start), .clear_busy(clear_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: word array plus count of clear cycles still to run
  logic [DW-1:0] m_mem [DEPTH];
  int            clear_left = DEPTH;
  logic          e_valid = 1'b0;
  logic [DW-1:0] e_rdata = '0;
  logic          e_err   = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic void zero_model();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endfunction

  // Drive one cycle, advance the model, then check all outputs after the edge
  task automatic step(input logic rst, input logic v, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [3:0] be, input logic cs);
    bit oor;
    int idx;
    reset = rst; req_valid = v; req_write = w; req_addr = a;
    req_wdata = wd; req_be = be; clear_start = cs;
    if (rst) begin
      clear_left = DEPTH; e_valid = 1'b0; e_rdata = '0; e_err = 1'b0;
      zero_model();
    end else if (clear_left > 0) begin
      clear_left--; e_valid = 1'b0;
    end else begin
      e_valid = v;
      if (v) begin
        oor   = CHK && (a >= AW'(DEPTH));
        idx   = int'(a % DEPTH);
        e_err = oor;
        if (w) begin
          e_rdata = '0;
          if (!oor)
            for (int b = 0; b < 4; b++)
              if (be[b]) m_mem[idx][8*b +: 8] = wd[8*b +: 8];
        end else begin
          e_rdata = oor ? '0 : m_mem[idx];
        end
      end
      if (cs) begin
        clear_left = DEPTH;
        zero_model();
      end
    end
    @(posedge clk);
    #1;
    chk("req_ready",  DW'(req_ready),  DW'(clear_left == 0));
    chk("clear_busy", DW'(clear_busy), DW'(clear_left != 0));
    chk("rsp_valid",  DW'(rsp_valid),  DW'(e_valid));
    chk("rsp_rdata",  rsp_rdata,       e_rdata);
    chk("rsp_err",    DW'(rsp_err),    DW'(e_err));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    step(1'b0, 1'b1, 1'b1, a, d, be, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b1, 1'b0, a, '0, 4'h0, 1'b0);
  endtask

  // Count cycles until ready rises; bounded
  task automatic busy_len(input string name);
    int n = 0;
    while (!req_ready && n < 400) begin
      idle();
      n++;
    end
    chk(name, DW'(n), DW'(DEPTH));
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; clear_start = 1'b0;
    zero_model();

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, AW'(i), '1, 4'hF, 1'b0);
    chk("reset_ready", DW'(req_ready), 0);
    chk("reset_busy",  DW'(clear_busy), 1);
    busy_len("clear_len_after_reset");

    rd(AW'(255));
    chk("lit_read255", rsp_rdata, 32'h0000_0000);

    wr(AW'(5), 32'hDEAD_BEEF, 4'hF);
    rd(AW'(5));
    chk("lit_read5", rsp_rdata, 32'hDEAD_BEEF);

    wr(AW'(7), 32'h1122_3344, 4'hF);
    wr(AW'(7), 32'hAABB_CCDD, 4'h5);
    rd(AW'(7));
    chk("lit_read7_be", rsp_rdata, 32'h11BB_33DD);

    for (int i = 0; i < 4; i++) wr(AW'(i), 32'hA000_0000 + DW'(i), 4'hF);
    for (int i = 0; i < 4; i++) begin
      rd(AW'(i));
      chk("lit_b2b_valid", DW'(rsp_valid), 1);
      chk("lit_b2b_data",  rsp_rdata, 32'hA000_0000 + DW'(i));
    end

    step(1'b0, 1'b1, 1'b1, AW'(9), 32'h1234_5678, 4'hF, 1'b1);
    chk("lit_clr_write_rsp", DW'(rsp_valid), 1);
    busy_len("clear_len_after_start");
    rd(AW'(9));
    chk("lit_read9_cleared", rsp_rdata, 32'h0);

    wr(AW'(256), 32'hFFFF_FFFF, 4'hF);
    chk("lit_oor_err", DW'(rsp_err), DW'(CHK));
    rd(AW'(0));
    chk("lit_read0", rsp_rdata, CHK ? 32'h0 : 32'hFFFF_FFFF);
    chk("lit_read0_err", DW'(rsp_err), 0);

    // Reset with a response pending, and reset mid-clear
    rd(AW'(3));
    step(1'b1, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
    chk("lit_rst_drop", DW'(rsp_valid), 0);
    busy_len("clear_len_rst1");
    step(1'b0, 1'b0, 1'b0, '0, '0, 4'h0, 1'b1);
    for (int i = 0; i < 40; i++) idle();
    step(1'b1, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0);
    busy_len("clear_len_midclear");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 300));
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
           a, DW'($urandom), 4'($urandom), ($urandom_range(0, 299) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
